// File: rtl/pipe_scheduler.sv
// Pipe scheduler: moves two scrolling pipes, re-rolls gap heights on wrap and
// counts pipes passed by the bird. Optional macro PIPE_SPEEDUP_EN enables score-based speed-up.
module pipe_scheduler #(
    parameter int D_WIDTH     = 640,
    parameter int D_HEIGHT    = 480,
    parameter int PIPE_HALF_W = 20,
    parameter int SPACING     = 360,
    parameter int SPEED       = 2,
    parameter int BIRD_X      = 160
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_animate,
    input  logic        i_start,
    input  logic        i_collide,
    output logic [11:0] o_p0_x,
    output logic [11:0] o_p1_x,
    output logic [11:0] o_p0_gap,
    output logic [11:0] o_p1_gap,
    output logic        o_running,
    output logic [7:0]  o_score
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_RUN    = 2'd1;
    localparam logic [1:0]  S_OVER   = 2'd2;
    localparam logic [11:0] X0_INIT  = 12'(D_WIDTH + PIPE_HALF_W);
    localparam logic [11:0] X1_INIT  = 12'(D_WIDTH + PIPE_HALF_W + SPACING);
    localparam logic [11:0] GAP_INIT = 12'(D_HEIGHT / 2);
    localparam logic [11:0] WRAP_ADD = 12'(2 * SPACING);
    localparam logic [11:0] HALF_W   = 12'(PIPE_HALF_W);
    localparam logic [11:0] BX       = 12'(BIRD_X);
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        w_running_next;
    logic        w_load_init;
    logic        w_move;
    logic        r_running;
    logic [11:0] r_p0_x, r_p1_x, r_p0_gap, r_p1_gap;
    logic [7:0]  r_score;
    logic [7:0]  r_lfsr;
    logic        w_lfsr_fb;
    logic [11:0] w_spd;
    logic        w_wrap0, w_wrap1, w_cross0, w_cross1;
    logic [11:0] w_p0_next, w_p1_next, w_gap_roll;
    logic [1:0]  w_inc;
    logic [8:0]  w_sum;
    logic [7:0]  w_score_next;

`ifdef PIPE_SPEEDUP_EN
    logic [4:0] w_boost_raw;
    logic [1:0] w_boost;
    assign w_boost_raw = r_score[7:3];
    assign w_boost     = (w_boost_raw > 5'd3) ? 2'd3 : w_boost_raw[1:0];
    assign w_spd       = 12'(SPEED) + {10'd0, w_boost};
`else
    assign w_spd = 12'(SPEED);
`endif

    // Movement with wrap: a wrapped pipe keeps its phase modulo 2*SPACING.
    assign w_wrap0    = r_p0_x < (HALF_W + w_spd);
    assign w_wrap1    = r_p1_x < (HALF_W + w_spd);
    assign w_p0_next  = w_wrap0 ? (r_p0_x + WRAP_ADD - w_spd) : (r_p0_x - w_spd);
    assign w_p1_next  = w_wrap1 ? (r_p1_x + WRAP_ADD - w_spd) : (r_p1_x - w_spd);
    assign w_cross0   = (r_p0_x >= BX) && (w_p0_next < BX);
    assign w_cross1   = (r_p1_x >= BX) && (w_p1_next < BX);
    assign w_inc      = {1'b0, w_cross0} + {1'b0, w_cross1};
    assign w_sum      = {1'b0, r_score} + {7'd0, w_inc};
    assign w_score_next = w_sum[8] ? 8'hFF : w_sum[7:0];
    assign w_gap_roll = 12'd120 + {4'd0, r_lfsr};
    assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = i_start   ? S_RUN  : S_IDLE;
            S_RUN:   w_state_next = i_collide ? S_OVER : S_RUN;
            S_OVER:  w_state_next = i_start   ? S_IDLE : S_OVER;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output/control decode; movement only when staying in RUN.
    always_comb begin
        w_running_next = (w_state_next == S_RUN);
        w_load_init    = (w_state_next == S_IDLE);
        w_move         = (r_state == S_RUN) && (w_state_next == S_RUN) && i_animate;
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_load_init) begin
            r_p0_x   <= X0_INIT;
            r_p1_x   <= X1_INIT;
            r_p0_gap <= GAP_INIT;
            r_p1_gap <= GAP_INIT;
            r_score  <= 8'd0;
        end else if (w_move) begin
            r_p0_x   <= w_p0_next;
            r_p1_x   <= w_p1_next;
            r_p0_gap <= w_wrap0 ? w_gap_roll : r_p0_gap;
            r_p1_gap <= w_wrap1 ? w_gap_roll : r_p1_gap;
            r_score  <= w_score_next;
        end else begin
            r_p0_x   <= r_p0_x;
            r_p1_x   <= r_p1_x;
            r_p0_gap <= r_p0_gap;
            r_p1_gap <= r_p1_gap;
            r_score  <= r_score;
        end
    end

    // Running flag and free-running LFSR.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_running <= 1'b0;
            r_lfsr    <= LFSR_SEED;
        end else begin
            r_running <= w_running_next;
            r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    assign o_p0_x    = r_p0_x;
    assign o_p1_x    = r_p1_x;
    assign o_p0_gap  = r_p0_gap;
    assign o_p1_gap  = r_p1_gap;
    assign o_running = r_running;
    assign o_score   = r_score;

endmodule
